selftrig_seq_ctrl: RTL and testbench

Per-channel sequencer for the IIR pedestal-recovery / moving-mean CFD self-trigger datapath. Drives the filter's enable, n_1_reset and threshold inputs, and flushes filter state at start-up and after saturation. Qualifies the filter's level trigger into single-cycle, timestamped trigger events with programmable dead time. Sits between the channel's config registers and the spy/readout trigger input.

---
 rtl/selftrig_seq_ctrl_pkg.sv | 21 ++
 rtl/selftrig_seq_ctrl_sat_detector.sv | 33 +++
 rtl/selftrig_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_selftrig_seq_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/selftrig_seq_ctrl_pkg.sv
// Shared types and constants for the self-trigger sequencer.
// Saturation recovery is built only when SELFTRIG_SAT_RECOVERY_EN is defined.
package selftrig_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FLUSH   = 3'd1,
    ST_SETTLE  = 3'd2,
    ST_ARMED   = 3'd3,
    ST_HOLDOFF = 3'd4
  } state_e;

  localparam logic signed [15:0] SAT_POS = 16'sh7FFF;
  localparam logic signed [15:0] SAT_NEG = 16'sh8000;

  localparam int TRIG_CNT_W = 32;
  localparam int MISS_CNT_W = 16;
  localparam int SATF_CNT_W = 16;
  localparam int TMR_W      = 32;

endpackage

// File: rtl/selftrig_seq_ctrl_sat_detector.sv
// Counts consecutive saturated filter samples; sat_hit flags the sample that
// reaches SAT_LIMIT. Used only when SELTRIG recovery (SELFTRIG_SAT_RECOVERY_EN) is built.
module selftrig_sat_detector
  import selftrig_pkg::*;
#(
  parameter int SAT_LIMIT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic signed [15:0] filt_y,
  input  logic               clear,
  output logic               sat_hit
);

  localparam int CW = (SAT_LIMIT < 2) ? 1 : $clog2(SAT_LIMIT + 1);

  logic [CW-1:0] run_q, run_d;
  logic          sat;

  assign sat     = (filt_y == SAT_POS) || (filt_y == SAT_NEG);
  assign sat_hit = sat && !clear && (run_q == CW'(SAT_LIMIT - 1));

  always_comb begin
    run_d = run_q + 1'b1;
    if (clear || !sat || sat_hit) run_d = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) run_q <= '0;
    else       run_q <= run_d;
  end

endmodule

// File: rtl/selftrig_seq_ctrl.sv
// Self-trigger sequencer: flush/settle the filter, qualify level triggers into
// timestamped pulses with dead time. Optional macro: SELFTRIG_SAT_RECOVERY_EN.
module selftrig_seq_ctrl
  import selftrig_pkg::*;
#(
  parameter int FLUSH_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 256,
  parameter int SAT_LIMIT     = 8,
  parameter int TS_W          = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_enable,
  input  logic signed [31:0]    cfg_threshold,
  input  logic [15:0]           cfg_holdoff,
  input  logic [TS_W-1:0]       ts,
  input  logic signed [15:0]    filt_y,
  input  logic                  filt_trigger,
  output logic                  filt_enable,
  output logic                  filt_n_1_reset,
  output logic signed [31:0]    filt_threshold,
  output logic                  trig_out,
  output logic [TS_W-1:0]       trig_ts,
  output logic [TRIG_CNT_W-1:0] trig_count,
  output logic [MISS_CNT_W-1:0] missed_count,
  output logic [SATF_CNT_W-1:0] sat_flush_count,
  output logic [2:0]            state_o
);

  state_e                state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic                  trig_d1_q;
  logic                  trig_edge;
  logic                  sat_hit;
  logic                  accept, missed_inc, sat_flush_inc, load_thr;
  logic                  filt_enable_q, filt_n_1_reset_q, trig_out_q;
  logic signed [31:0]    thr_q;
  logic [TS_W-1:0]       trig_ts_q;
  logic [TRIG_CNT_W-1:0] trig_count_q;
  logic [MISS_CNT_W-1:0] missed_count_q;

  assign trig_edge = filt_trigger & ~trig_d1_q;

`ifdef SELFTRIG_SAT_RECOVERY_EN
  logic                  sat_clear;
  logic [SATF_CNT_W-1:0] sat_flush_count_q;

  // Run length only counts while the filter output is being qualified.
  assign sat_clear = !((state_q == ST_ARMED) || (state_q == ST_HOLDOFF));

  selftrig_sat_detector #(.SAT_LIMIT(SAT_LIMIT)) u_sat (
    .clk     (clk),
    .reset   (reset),
    .filt_y  (filt_y),
    .clear   (sat_clear),
    .sat_hit (sat_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) sat_flush_count_q <= '0;
    else if (sat_flush_inc && (sat_flush_count_q != '1))
      sat_flush_count_q <= sat_flush_count_q + 1'b1;
  end

  assign sat_flush_count = sat_flush_count_q;
`else
  logic unused_sat;
  assign sat_hit         = 1'b0;
  assign unused_sat      = sat_flush_inc ^ (^filt_y);
  assign sat_flush_count = '0;
`endif

  always_comb begin
    state_d       = state_q;
    tmr_d         = tmr_q;
    accept        = 1'b0;
    missed_inc    = 1'b0;
    sat_flush_inc = 1'b0;
    load_thr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          state_d  = ST_FLUSH;
          tmr_d    = TMR_W'(FLUSH_CYCLES - 1);
          load_thr = 1'b1;
        end
      end
      ST_FLUSH: begin
        if (tmr_q == '0) begin
          state_d = ST_SETTLE;
          tmr_d   = TMR_W'(SETTLE_CYCLES - 1);
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      ST_SETTLE: begin
        if (tmr_q == '0) state_d = ST_ARMED;
        else             tmr_d   = tmr_q - 1'b1;
      end
      ST_ARMED: begin
        if (sat_hit) begin
          // Saturation flush takes precedence; a coincident edge is lost.
          state_d       = ST_FLUSH;
          tmr_d         = TMR_W'(FLUSH_CYCLES - 1);
          load_thr      = 1'b1;
          sat_flush_inc = 1'b1;
          missed_inc    = trig_edge;
        end else if (trig_edge) begin
          accept  = 1'b1;
          state_d = ST_HOLDOFF;
          tmr_d   = (cfg_holdoff == 16'd0) ? '0 : TMR_W'(cfg_holdoff - 16'd1);
        end
      end
      ST_HOLDOFF: begin
        missed_inc = trig_edge;
        if (sat_hit) begin
          state_d       = ST_FLUSH;
          tmr_d         = TMR_W'(FLUSH_CYCLES - 1);
          load_thr      = 1'b1;
          sat_flush_inc = 1'b1;
        end else if (tmr_q == '0) begin
          state_d = ST_ARMED;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (!cfg_enable) begin
      state_d       = ST_IDLE;
      accept        = 1'b0;
      missed_inc    = 1'b0;
      sat_flush_inc = 1'b0;
      load_thr      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ST_IDLE;
      tmr_q            <= '0;
      trig_d1_q        <= 1'b0;
      filt_enable_q    <= 1'b0;
      filt_n_1_reset_q <= 1'b0;
      thr_q            <= '0;
      trig_out_q       <= 1'b0;
      trig_ts_q        <= '0;
      trig_count_q     <= '0;
      missed_count_q   <= '0;
    end else begin
      state_q          <= state_d;
      tmr_q            <= tmr_d;
      trig_d1_q        <= ((state_q == ST_IDLE) || (state_q == ST_FLUSH)) ? 1'b0 : filt_trigger;
      // Decode from the next state so these flops line up with state_q.
      filt_enable_q    <= (state_d == ST_SETTLE) || (state_d == ST_ARMED) ||
                          (state_d == ST_HOLDOFF);
      filt_n_1_reset_q <= (state_d == ST_FLUSH);
      trig_out_q       <= accept;
      if (load_thr) thr_q <= cfg_threshold;
      if (accept) begin
        trig_ts_q <= ts;
        if (trig_count_q != '1) trig_count_q <= trig_count_q + 1'b1;
      end
      if (missed_inc && (missed_count_q != '1))
        missed_count_q <= missed_count_q + 1'b1;
    end
  end

  assign filt_enable    = filt_enable_q;
  assign filt_n_1_reset = filt_n_1_reset_q;
  assign filt_threshold = thr_q;
  assign trig_out       = trig_out_q;
  assign trig_ts        = trig_ts_q;
  assign trig_count     = trig_count_q;
  assign missed_count   = missed_count_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_selftrig_seq_ctrl.sv
// Scoreboard bench for selftrig_seq_ctrl: expected trigger events are queued by
// the stimulus and popped by a monitor on every trig_out pulse.
module tb_selftrig_seq_ctrl;

  logic               clk = 1'b0;
  logic               reset;
  logic               cfg_enable;
  logic signed [31:0] cfg_threshold;
  logic [15:0]        cfg_holdoff;
  logic [63:0]        ts = '0;
  logic signed [15:0] filt_y;
  logic               filt_trigger;
  logic               filt_enable, filt_n_1_reset, trig_out;
  logic signed [31:0] filt_threshold;
  logic [63:0]        trig_ts;
  logic [31:0]        trig_count;
  logic [15:0]        missed_count, sat_flush_count;
  logic [2:0]         state_o;

  typedef struct {
    logic [63:0] ts;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [63:0] last_ts;
  int          exp_missed;

  selftrig_seq_ctrl dut (
    .clk             (clk),
    .reset           (reset),
    .cfg_enable      (cfg_enable),
    .cfg_threshold   (cfg_threshold),
    .cfg_holdoff     (cfg_holdoff),
    .ts              (ts),
    .filt_y          (filt_y),
    .filt_trigger    (filt_trigger),
    .filt_enable     (filt_enable),
    .filt_n_1_reset  (filt_n_1_reset),
    .filt_threshold  (filt_threshold),
    .trig_out        (trig_out),
    .trig_ts         (trig_ts),
    .trig_count      (trig_count),
    .missed_count    (missed_count),
    .sat_flush_count (sat_flush_count),
    .state_o         (state_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ts <= ts + 64'd1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] cnt);
    exp_t e;
    e.ts  = ts;
    e.cnt = cnt;
    exp_q.push_back(e);
    last_ts = ts;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max_cyc, input string name);
    int k = 0;
    while (state_o !== s && k < max_cyc) begin
      tick();
      k++;
    end
    check(name, 64'(state_o), 64'(s));
  endtask

  // Monitor: every accepted-trigger pulse must match the oldest queued event.
  always @(negedge clk) begin
    if (!reset && trig_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_trig", 64'(trig_ts), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("trig_ts", trig_ts, e.ts);
        check("trig_count_evt", 64'(trig_count), 64'(e.cnt));
      end
    end
  end

  initial begin
    reset         = 1'b1;
    cfg_enable    = 1'b0;
    cfg_threshold = 32'sh1234_5678;
    cfg_holdoff   = 16'd20;
    filt_y        = 16'sd0;
    filt_trigger  = 1'b0;
    exp_missed    = 3;
    last_ts       = '0;
    repeat (3) tick();
    check("rst_state", 64'(state_o), 64'd0);
    check("rst_outs", 64'({filt_enable, filt_n_1_reset, trig_out}), 64'd0);
    check("rst_thr", 64'(filt_threshold), 64'd0);
    check("rst_cnt", {trig_count, missed_count, sat_flush_count}, 64'd0);
    check("rst_ts", trig_ts, 64'd0);
    reset = 1'b0;

    // Start-up: 4 flush cycles, 256 settle cycles with triggers ignored.
    cfg_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush", 64'({state_o, filt_n_1_reset, filt_enable}), 64'({3'd1, 1'b1, 1'b0}));
    end
    check("thr_latch", 64'(filt_threshold), 64'h1234_5678);
    for (int i = 0; i < 256; i++) begin
      tick();
      check("settle", 64'({state_o, filt_n_1_reset, filt_enable, trig_out}),
            64'({3'd2, 1'b0, 1'b1, 1'b0}));
      filt_trigger = (i >= 10 && i <= 12) || (i == 100);
    end
    tick();
    check("armed", 64'({state_o, filt_enable}), 64'({3'd3, 1'b1}));

    // Held-high trigger at ts=1000 produces one event.
    begin
      int k = 0;
      while (ts != 64'd1000 && k < 2000) begin
        tick();
        k++;
      end
      check("ts_reach", ts, 64'd1000);
    end
    filt_trigger = 1'b1;
    push_exp(32'd1);
    tick();
    check("holdoff_entry", 64'(state_o), 64'd4);
    repeat (49) tick();
    filt_trigger = 1'b0;
    tick();
    check("t2_counts", 64'({trig_count, missed_count}), 64'({32'd1, 16'd0}));
    check("t2_state", 64'(state_o), 64'd3);

    // Holdoff 100: edges at +10/+40/+90 missed, +101 accepted.
    cfg_holdoff  = 16'd100;
    filt_trigger = 1'b1;
    push_exp(32'd2);
    tick();
    for (int k = 1; k <= 101; k++) begin
      filt_trigger = (k == 10) || (k == 40) || (k == 90) || (k == 101);
      if (k == 101) push_exp(32'd3);
      tick();
    end
    filt_trigger = 1'b0;
    tick();
    check("t3_counts", 64'({trig_count, missed_count}), 64'({32'd3, 16'd3}));
    wait_state(3'd3, 150, "t3_rearm");

    // Holdoff 0 behaves as a single cycle.
    cfg_holdoff  = 16'd0;
    filt_trigger = 1'b1;
    push_exp(32'd4);
    tick();
    filt_trigger = 1'b0;
    tick();
    check("t4_rearm", 64'(state_o), 64'd3);
    filt_trigger = 1'b1;
    push_exp(32'd5);
    tick();
    check("t4_accept", 64'(state_o), 64'd4);
    filt_trigger = 1'b0;
    tick();
    check("t4_back", 64'(state_o), 64'd3);

`ifdef SELFTRIG_SAT_RECOVERY_EN
    filt_y = 16'sh7FFF;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("sat_run", 64'(state_o), 64'd3);
    end
    tick();
    check("sat_flush", 64'({state_o, sat_flush_count}), 64'({3'd1, 16'd1}));
    filt_y = 16'sd0;
    wait_state(3'd3, 400, "sat_rearm1");
    filt_y = 16'sh7FFF;
    repeat (7) tick();
    filt_y = 16'sd0;
    tick();
    check("sat_break", 64'({state_o, sat_flush_count}), 64'({3'd3, 16'd1}));
    filt_y = -16'sd32768;
    repeat (7) tick();
    filt_trigger = 1'b1;
    tick();
    exp_missed = 4;
    check("sat_vs_edge", 64'({state_o, trig_out, sat_flush_count, missed_count}),
          64'({3'd1, 1'b0, 16'd2, 16'd4}));
    filt_trigger = 1'b0;
    filt_y       = 16'sd0;
    wait_state(3'd3, 400, "sat_rearm2");
`else
    filt_y = 16'sh7FFF;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("no_sat", 64'({state_o, sat_flush_count}), 64'({3'd3, 16'd0}));
    end
    filt_y = 16'sd0;
`endif

    // Threshold only moves on FLUSH entry; disable aborts settle.
    cfg_threshold = 32'shCAFE_0001;
    repeat (3) tick();
    check("thr_stable", 64'(filt_threshold), 64'h1234_5678);
    cfg_enable = 1'b0;
    tick();
    check("disable", 64'({state_o, filt_enable, filt_n_1_reset}), 64'({3'd0, 1'b0, 1'b0}));
    check("kept_cnt", 64'({trig_count, 16'(exp_missed)}), 64'({32'd5, missed_count}));
    check("kept_ts", trig_ts, last_ts);
    cfg_enable = 1'b1;
    tick();
    check("reen_thr", 64'({state_o, filt_threshold}), 64'({3'd1, 32'hCAFE_0001}));
    repeat (4) tick();
    repeat (50) tick();
    check("mid_settle", 64'(state_o), 64'd2);
    cfg_threshold = 32'sh0BAD_BEEF;
    cfg_enable    = 1'b0;
    tick();
    check("abort_settle", 64'(state_o), 64'd0);
    cfg_enable = 1'b1;
    tick();
    check("reen_thr2", 64'({state_o, filt_threshold}), 64'({3'd1, 32'h0BAD_BEEF}));

    repeat (10) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
